// File: rtl/rs_alloc_unit_pkg.sv
// Shared dispatch/RS constants and encodings for the RS allocation slice.
package rs_alloc_unit_pkg;

    localparam int DP_NUM_WIDTH = 2;

    typedef enum logic [1:0] {
        RS_SEL_ALU    = 2'd0,
        RS_SEL_MUL    = 2'd1,
        RS_SEL_LDST   = 2'd2,
        RS_SEL_BRANCH = 2'd3
    } rs_sel_e;

    localparam int RS_ENT_NUM_ALU    = 8;
    localparam int RS_ENT_NUM_MUL    = 4;
    localparam int RS_ENT_NUM_LDST   = 8;
    localparam int RS_ENT_NUM_BRANCH = 4;

endpackage

// File: rtl/rs_alloc_unit_if.sv
// Dispatch/issue/flush bundle between the RS allocator and its neighbours.
interface rs_alloc_unit_if
    import rs_alloc_unit_pkg::*;
#(
    parameter int RS_ENT_NUM = 8,
    parameter int RS_ENT_SEL = 3
);
    logic                    i_rs_req_1;
    logic                    i_rs_req_2;
    logic [DP_NUM_WIDTH-1:0] i_rs_req_num;
    logic                    i_dp_stall;
    logic                    i_issue_vld;
    logic [RS_ENT_SEL-1:0]   i_issue_ptr;
    logic                    i_kill_vld;
    logic [RS_ENT_NUM-1:0]   i_kill_mask;
    logic                    o_we_1;
    logic                    o_we_2;
    logic [RS_ENT_SEL-1:0]   o_wptr_1;
    logic [RS_ENT_SEL-1:0]   o_wptr_2;
    logic                    o_rs_full_stall;
    logic [RS_ENT_SEL:0]     o_free_num;
    logic [RS_ENT_NUM-1:0]   o_ent_vld;

    modport master (
        output i_rs_req_1, i_rs_req_2, i_rs_req_num, i_dp_stall,
        output i_issue_vld, i_issue_ptr, i_kill_vld, i_kill_mask,
        input  o_we_1, o_we_2, o_wptr_1, o_wptr_2,
        input  o_rs_full_stall, o_free_num, o_ent_vld
    );

    modport slave (
        input  i_rs_req_1, i_rs_req_2, i_rs_req_num, i_dp_stall,
        input  i_issue_vld, i_issue_ptr, i_kill_vld, i_kill_mask,
        output o_we_1, o_we_2, o_wptr_1, o_wptr_2,
        output o_rs_full_stall, o_free_num, o_ent_vld
    );

endinterface

// File: rtl/rs_alloc_unit_free_picker.sv
// Two cascaded lowest-zero encoders; issue-select reuses it on the inverted map.
module rs_free_picker #(
    parameter int RS_ENT_NUM = 8,
    parameter int RS_ENT_SEL = $clog2(RS_ENT_NUM)
) (
    input  logic [RS_ENT_NUM-1:0] vld_i,
    output logic [RS_ENT_SEL-1:0] f1_o,
    output logic [RS_ENT_SEL-1:0] f2_o,
    output logic                  have1_o,
    output logic                  have2_o
);

    logic [RS_ENT_NUM-1:0] vld2;

    always_comb begin
        f1_o    = '0;
        have1_o = 1'b0;
        for (int i = RS_ENT_NUM - 1; i >= 0; i--) begin
            if (!vld_i[i]) begin
                f1_o    = RS_ENT_SEL'(i);
                have1_o = 1'b1;
            end
        end
    end

    // Mask off the first pick so the second encoder finds the next zero.
    always_comb begin
        vld2 = vld_i;
        if (have1_o)
            vld2[f1_o] = 1'b1;
    end

    always_comb begin
        f2_o    = '0;
        have2_o = 1'b0;
        for (int i = RS_ENT_NUM - 1; i >= 0; i--) begin
            if (!vld2[i]) begin
                f2_o    = RS_ENT_SEL'(i);
                have2_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_alloc_unit.sv
// Reservation-station entry allocator: grants up to two free slots per cycle.
module rs_alloc_unit
    import rs_alloc_unit_pkg::*;
#(
    parameter int RS_ENT_NUM = 8,
    parameter int RS_ENT_SEL = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    rs_alloc_unit_if.slave bus
);

    logic [RS_ENT_NUM-1:0] ent_vld_q, ent_vld_d;
    logic [RS_ENT_SEL:0]   free_num_q, free_num_d;

    logic [RS_ENT_SEL-1:0] f1, f2;
    logic                  have1, have2;
    logic                  stall, grant;
    logic                  we_1, we_2;
    logic [RS_ENT_SEL-1:0] wptr_2;
    logic [RS_ENT_NUM-1:0] set_mask, clr_mask;
    logic [RS_ENT_SEL:0]   vld_cnt;

    rs_free_picker #(
        .RS_ENT_NUM (RS_ENT_NUM),
        .RS_ENT_SEL (RS_ENT_SEL)
    ) u_picker (
        .vld_i   (ent_vld_q),
        .f1_o    (f1),
        .f2_o    (f2),
        .have1_o (have1),
        .have2_o (have2)
    );

    // All-or-nothing: a pair that does not fit is stalled as a whole.
    assign stall  = (RS_ENT_SEL+1)'(bus.i_rs_req_num) > free_num_q;
    assign grant  = !stall && !bus.i_dp_stall;
    assign we_1   = grant && bus.i_rs_req_1;
    assign we_2   = grant && bus.i_rs_req_2;
    assign wptr_2 = bus.i_rs_req_1 ? f2 : f1;

    always_comb begin
        set_mask = '0;
        if (we_1) set_mask[f1]     = 1'b1;
        if (we_2) set_mask[wptr_2] = 1'b1;
        clr_mask = '0;
        if (bus.i_issue_vld) clr_mask[bus.i_issue_ptr] = 1'b1;
        if (bus.i_kill_vld)  clr_mask = clr_mask | bus.i_kill_mask;
        // Set before clear so a same-cycle squash wins over the grant.
        ent_vld_d = (ent_vld_q | set_mask) & ~clr_mask;
    end

    always_comb begin
        vld_cnt = '0;
        for (int i = 0; i < RS_ENT_NUM; i++)
            vld_cnt = vld_cnt + (RS_ENT_SEL+1)'(ent_vld_d[i]);
        free_num_d = (RS_ENT_SEL+1)'(RS_ENT_NUM) - vld_cnt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ent_vld_q  <= '0;
            free_num_q <= (RS_ENT_SEL+1)'(RS_ENT_NUM);
        end else begin
            ent_vld_q  <= ent_vld_d;
            free_num_q <= free_num_d;
        end
    end

    assign bus.o_we_1          = we_1;
    assign bus.o_we_2          = we_2;
    assign bus.o_wptr_1        = f1;
    assign bus.o_wptr_2        = wptr_2;
    assign bus.o_rs_full_stall = stall;
    assign bus.o_free_num      = free_num_q;
    assign bus.o_ent_vld       = ent_vld_q;

    a_req_num: assert property (@(posedge i_clk) disable iff (i_rst)
        bus.i_rs_req_num ==
        DP_NUM_WIDTH'(bus.i_rs_req_1) + DP_NUM_WIDTH'(bus.i_rs_req_2));

    a_have1: assert property (@(posedge i_clk) disable iff (i_rst)
        (we_1 || we_2) |-> have1);

    a_have2: assert property (@(posedge i_clk) disable iff (i_rst)
        (we_1 && we_2) |-> have2);

endmodule

// File: tb/tb_rs_alloc_unit.sv
// Directed plus randomized check of rs_alloc_unit against a free-list model.
module tb_rs_alloc_unit;

    localparam int N = 8;
    localparam int S = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rs_alloc_unit_if #(.RS_ENT_NUM(N), .RS_ENT_SEL(S)) bus ();

    rs_alloc_unit #(
        .RS_ENT_NUM (N),
        .RS_ENT_SEL (S)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int nvec = 0;
    int nerr = 0;

    bit [N-1:0] m_vld = '0;

    logic       s_we1, s_we2, s_stall;
    logic [S-1:0] s_w1, s_w2;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_free(input bit [N-1:0] v);
        int c = 0;
        for (int i = 0; i < N; i++)
            if (!v[i]) c++;
        return c;
    endfunction

    task automatic step(input bit r, input bit r1, input bit r2,
                        input bit dps, input bit iv, input int ip,
                        input bit kv, input logic [N-1:0] km);
        int fq[$];
        int num, p1, p2;
        bit e_stall, e_grant, e_we1, e_we2;
        bit [N-1:0] nv;
        @(negedge clk);
        rst              = r;
        num              = int'(r1) + int'(r2);
        bus.i_rs_req_1   = r1;
        bus.i_rs_req_2   = r2;
        bus.i_rs_req_num = 2'(num);
        bus.i_dp_stall   = dps;
        bus.i_issue_vld  = iv;
        bus.i_issue_ptr  = S'(ip);
        bus.i_kill_vld   = kv;
        bus.i_kill_mask  = km;
        #1;
        for (int i = 0; i < N; i++)
            if (!m_vld[i]) fq.push_back(i);
        e_stall = num > fq.size();
        e_grant = !e_stall && !dps;
        e_we1   = e_grant && r1;
        e_we2   = e_grant && r2;
        p1 = (fq.size() > 0) ? fq[0] : 0;
        p2 = r1 ? ((fq.size() > 1) ? fq[1] : 0) : p1;
        s_we1   = bus.o_we_1;
        s_we2   = bus.o_we_2;
        s_w1    = bus.o_wptr_1;
        s_w2    = bus.o_wptr_2;
        s_stall = bus.o_rs_full_stall;
        chk("stall", 32'(s_stall), 32'(e_stall));
        chk("we_1", 32'(s_we1), 32'(e_we1));
        chk("we_2", 32'(s_we2), 32'(e_we2));
        if (e_we1) chk("wptr_1", 32'(s_w1), 32'(p1));
        if (e_we2) chk("wptr_2", 32'(s_w2), 32'(p2));
        nv = m_vld;
        if (e_we1) nv[p1] = 1'b1;
        if (e_we2) nv[p2] = 1'b1;
        if (iv) nv[ip] = 1'b0;
        if (kv) nv = nv & ~km;
        if (r) nv = '0;
        m_vld = nv;
        @(posedge clk);
        #1;
        chk("ent_vld", 32'(bus.o_ent_vld), 32'(m_vld));
        chk("free_num", 32'(bus.o_free_num), 32'(model_free(m_vld)));
    endtask

    initial begin
        bus.i_rs_req_1   = 1'b0;
        bus.i_rs_req_2   = 1'b0;
        bus.i_rs_req_num = '0;
        bus.i_dp_stall   = 1'b0;
        bus.i_issue_vld  = 1'b0;
        bus.i_issue_ptr  = '0;
        bus.i_kill_vld   = 1'b0;
        bus.i_kill_mask  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", 32'(bus.o_ent_vld), 32'h0);
        chk("rst_free", 32'(bus.o_free_num), 32'd8);
        chk("rst_we1", 32'(bus.o_we_1), 32'h0);
        chk("rst_stall", 32'(bus.o_rs_full_stall), 32'h0);

        step(0, 1, 1, 0, 0, 0, 0, '0);
        chk("tp1_w1", 32'(s_w1), 32'd0);
        chk("tp1_w2", 32'(s_w2), 32'd1);
        chk("tp1_vld", 32'(bus.o_ent_vld), 32'h03);
        chk("tp1_free", 32'(bus.o_free_num), 32'd6);

        step(0, 1, 0, 0, 0, 0, 0, '0);
        step(0, 0, 1, 0, 0, 0, 0, '0);
        chk("tp2_we1", 32'(s_we1), 32'd0);
        chk("tp2_w2", 32'(s_w2), 32'd3);
        chk("tp2_free", 32'(bus.o_free_num), 32'd4);

        step(0, 1, 0, 0, 0, 0, 0, '0);
        step(0, 1, 1, 0, 0, 0, 0, '0);
        step(0, 1, 0, 0, 0, 0, 0, '0);
        step(0, 0, 0, 0, 1, 5, 0, '0);
        chk("tp3_vld", 32'(bus.o_ent_vld), 32'hdf);
        step(0, 1, 1, 0, 0, 0, 0, '0);
        chk("tp3_stall", 32'(s_stall), 32'd1);
        chk("tp3_we2", 32'(s_we2), 32'd0);
        step(0, 1, 0, 0, 0, 0, 0, '0);
        chk("tp3_w1", 32'(s_w1), 32'd5);
        chk("tp3_free", 32'(bus.o_free_num), 32'd0);

        step(0, 1, 0, 0, 1, 4, 0, '0);
        chk("tp4_stall", 32'(s_stall), 32'd1);
        chk("tp4_free", 32'(bus.o_free_num), 32'd1);
        step(0, 1, 0, 0, 0, 0, 0, '0);
        chk("tp4_w1", 32'(s_w1), 32'd4);

        step(1, 0, 0, 0, 0, 0, 0, '0);
        step(0, 1, 1, 0, 0, 0, 1, 8'h02);
        chk("tp5_vld", 32'(bus.o_ent_vld), 32'h01);
        chk("tp5_free", 32'(bus.o_free_num), 32'd7);

        step(1, 0, 0, 0, 0, 0, 0, '0);
        step(0, 1, 1, 1, 0, 0, 0, '0);
        chk("tp6_stall", 32'(s_stall), 32'd0);
        chk("tp6_we1", 32'(s_we1), 32'd0);
        chk("tp6_vld", 32'(bus.o_ent_vld), 32'h00);
        step(0, 0, 0, 0, 1, 3, 0, '0);
        chk("iss_inv_free", 32'(bus.o_free_num), 32'd8);

        for (int k = 0; k < 500; k++) begin
            step($urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, N - 1)),
                 $urandom_range(0, 9) == 0,
                 N'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
